alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative shift-add
// multiply and restoring divide, with registered result and {N,Z,C,V} flags.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_EOR  = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_UDIV = 4'b1001;
    localparam int         CNT_W   = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_count;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    logic               w_multi;
    logic               w_last;
    logic [WIDTH:0]     w_sc_sum;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_c;
    logic               w_sc_v;
    logic [3:0]         w_sc_flags;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_rem;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [WIDTH-1:0]   w_work_next;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_iter_res;

    assign w_multi = (ALUControl == OP_MUL) || (ALUControl == OP_UDIV);
    assign w_last  = (r_count == CNT_W'(WIDTH - 1));

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        w_sc_sum = '0;
        w_sc_res = A;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                w_sc_sum = {1'b0, A} + {1'b0, B};
                w_sc_res = w_sc_sum[WIDTH-1:0];
                w_sc_c   = w_sc_sum[WIDTH];
                w_sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sc_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                w_sc_res = w_sc_sum[WIDTH-1:0];
                w_sc_c   = w_sc_sum[WIDTH];
                w_sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_sc_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  w_sc_res = A & B;
            OP_ORR:  w_sc_res = A | B;
            OP_EOR:  w_sc_res = A ^ B;
            OP_MOV:  w_sc_res = B;
            default: w_sc_res = A;
        endcase
        w_sc_flags = {w_sc_res[WIDTH-1], (w_sc_res == '0), w_sc_c, w_sc_v};
    end

    // {r_work, r_shift} is the product register for MUL and the remainder/quotient pair for UDIV.
    always_comb begin
        w_mul_sum  = {1'b0, r_work} + {1'b0, r_a & {WIDTH{r_shift[0]}}};
        w_div_rem  = {r_work, r_shift[WIDTH-1]};
        w_div_ge   = (w_div_rem >= {1'b0, r_b});
        w_div_diff = w_div_rem[WIDTH-1:0] - r_b;
        if (r_is_div) begin
            w_work_next  = w_div_ge ? w_div_diff : w_div_rem[WIDTH-1:0];
            w_shift_next = {r_shift[WIDTH-2:0], w_div_ge};
            w_iter_res   = (r_b == '0) ? '0 : w_shift_next;
        end else begin
            w_work_next  = w_mul_sum[WIDTH:1];
            w_shift_next = {w_mul_sum[0], r_shift[WIDTH-1:1]};
            w_iter_res   = w_shift_next;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_multi ? S_ITER : S_DONE;
            S_ITER:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_shift  <= '0;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_work   <= '0;
                        r_shift  <= (ALUControl == OP_UDIV) ? A : B;
                        r_count  <= '0;
                        r_is_div <= (ALUControl == OP_UDIV);
                        if (!w_multi) begin
                            r_result <= w_sc_res;
                            r_flags  <= w_sc_flags;
                        end
                    end
                end
                S_ITER: begin
                    r_work  <= w_work_next;
                    r_shift <= w_shift_next;
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_iter_res;
                        r_flags  <= {w_iter_res[WIDTH-1], (w_iter_res == '0), 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

    assign ALUResult = r_result;
    assign ALUFlags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, randomized ops against
// an arithmetic reference model, busy-time start rejection and mid-operation reset.
module tb_alu_seq;

    localparam int W = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [3:0]    ctl_in = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  alu_result;
    logic [3:0]    alu_flags;

    int n_total = 0;
    int n_bad   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .A          (a_in),
        .B          (b_in),
        .ALUControl (ctl_in),
        .busy       (busy),
        .done       (done),
        .ALUResult  (alu_result),
        .ALUFlags   (alu_flags)
    );

    always #5 clk = ~clk;

    // Reference: {N,Z,C,V, result} from plain integer arithmetic.
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] p;
        logic        c;
        logic        v;
        int          ia;
        int          ib;
        int          ir;
        longint      ss;
        ia = a;
        ib = b;
        c  = 1'b0;
        v  = 1'b0;
        ss = 0;
        case (op)
            4'b0000: begin
                r  = a + b;
                c  = ({32'b0, a} + {32'b0, b}) > 64'h0000_0000_FFFF_FFFF;
                ss = longint'(ia) + longint'(ib);
                ir = r;
                v  = (ss != longint'(ir));
            end
            4'b0001: begin
                r  = a - b;
                c  = (a >= b);
                ss = longint'(ia) - longint'(ib);
                ir = r;
                v  = (ss != longint'(ir));
            end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0111: r = b;
            4'b1000: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0];
            end
            4'b1001: r = (b == 0) ? 32'd0 : a / b;
            default: r = a;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        return (op == 4'b1000 || op == 4'b1001) ? W + 1 : 1;
    endfunction

    // Issue one operation, scramble inputs after acceptance, watch 40 cycles.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] flg,
                          output int lat, output int pulses);
        res = '0;
        flg = '0;
        lat = 0;
        pulses = 0;
        @(negedge clk);
        ctl_in = op;
        a_in   = a;
        b_in   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a_in   = $urandom;
        b_in   = $urandom;
        ctl_in = 4'($urandom_range(0, 15));
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    res = alu_result;
                    flg = alu_flags;
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({busy, done, alu_result, alu_flags} !== {2'b00, 32'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h flags=%b want 0/0/0/0000",
                     busy, done, alu_result, alu_flags);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        vec_t        v[11];
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          pulses;
        v[0]  = '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1};
        v[1]  = '{4'b0001, 32'd5,         32'd5,         32'h0000_0000, 4'b0110, 1};
        v[2]  = '{4'b0001, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000, 1};
        v[3]  = '{4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0100, 33};
        v[4]  = '{4'b1000, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 4'b0000, 33};
        v[5]  = '{4'b1001, 32'd100,       32'd7,         32'd14,        4'b0000, 33};
        v[6]  = '{4'b1001, 32'd9,         32'd0,         32'd0,         4'b0100, 33};
        v[7]  = '{4'b0111, 32'd1,         32'h0000_0080, 32'h0000_0080, 4'b0000, 1};
        v[8]  = '{4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 1};
        v[9]  = '{4'b0101, 32'h8000_0001, 32'h1234_5678, 32'h8000_0001, 4'b1000, 1};
        v[10] = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1};
        for (int k = 0; k < 11; k++) begin
            run_op(v[k].op, v[k].a, v[k].b, res, flg, lat, pulses);
            n_total++;
            if ({res, flg} !== {v[k].r, v[k].f}) begin
                n_bad++;
                $display("FAIL directed[%0d] result: got %h/%b want %h/%b", k, res, flg, v[k].r, v[k].f);
            end
            n_total++;
            if (lat != v[k].lat || pulses != 1) begin
                n_bad++;
                $display("FAIL directed[%0d] timing: got lat=%0d pulses=%0d want lat=%0d pulses=1",
                         k, lat, pulses, v[k].lat);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int         lat = 0;
        int         pulses = 0;
        logic [31:0] res = '0;
        logic [3:0]  flg = '0;
        @(negedge clk);
        ctl_in = 4'b1000;
        a_in   = 32'h0000_1234;
        b_in   = 32'h0000_0010;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5) begin
                n_total++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_mid_mul: got %b want 1", busy);
                end
                start  = 1'b1;
                ctl_in = 4'b0000;
                a_in   = 32'd1;
                b_in   = 32'd2;
            end else if (i == 6) begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    res = alu_result;
                    flg = alu_flags;
                end
            end
        end
        n_total++;
        if ({res, flg} !== {32'h0001_2340, 4'b0000} || lat != 33 || pulses != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore: got res=%h flags=%b lat=%0d pulses=%0d busy=%b want 00012340/0000/33/1/0",
                     res, flg, lat, pulses, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_cur;
        logic [31:0] b_cur;
        logic [35:0] e;
        int          pulses = 0;
        @(negedge clk);
        a_cur  = $urandom;
        b_cur  = $urandom;
        a_in   = a_cur;
        b_in   = b_cur;
        ctl_in = 4'b0001;
        start  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                e = model(4'b0001, a_cur, b_cur);
                n_total++;
                if ({alu_flags, alu_result} !== e) begin
                    n_bad++;
                    $display("FAIL back_to_back[%0d]: got %b/%h want %b/%h",
                             pulses, alu_flags, alu_result, e[35:32], e[31:0]);
                end
                a_cur = $urandom;
                b_cur = $urandom;
                a_in  = a_cur;
                b_in  = b_cur;
            end
        end
        start = 1'b0;
        n_total++;
        if (pulses != 4) begin
            n_bad++;
            $display("FAIL back_to_back_pulses: got %0d want 4", pulses);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] e;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          pulses;
        for (int k = 0; k < 40; k++) begin
            op = ($urandom_range(0, 2) == 0) ? (4'b1000 | 4'($urandom_range(0, 1)))
                                             : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                1:       a = $urandom_range(0, 1000);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            e = model(op, a, b);
            run_op(op, a, b, res, flg, lat, pulses);
            n_total++;
            if ({flg, res} !== e || lat != exp_lat(op) || pulses != 1) begin
                n_bad++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got %b/%h lat=%0d pulses=%0d want %b/%h lat=%0d pulses=1",
                         k, op, a, b, flg, res, lat, pulses, e[35:32], e[31:0], exp_lat(op));
            end
            n_total++;
            if ({alu_flags, alu_result} !== e) begin
                n_bad++;
                $display("FAIL random_hold[%0d]: got %b/%h want %b/%h",
                         k, alu_flags, alu_result, e[35:32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          pulses = 0;
        run_op(4'b0000, 32'h10, 32'h20, res, flg, lat, pulses);
        n_total++;
        if (res !== 32'h30) begin
            n_bad++;
            $display("FAIL reset_mid_setup: got %h want 00000030", res);
        end
        @(negedge clk);
        ctl_in = 4'b1001;
        a_in   = 32'd100;
        b_in   = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_total++;
        if ({busy, done, alu_result, alu_flags} !== {2'b00, 32'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_state: got busy=%b done=%b res=%h flags=%b want 0/0/0/0000",
                     busy, done, alu_result, alu_flags);
        end
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_total++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: got %0d pulses want 0", pulses);
        end
        run_op(4'b0000, 32'd2, 32'd2, res, flg, lat, pulses);
        n_total++;
        if ({res, flg} !== {32'd4, 4'b0000} || lat != 1 || pulses != 1) begin
            n_bad++;
            $display("FAIL reset_mid_recover: got %h/%b lat=%0d pulses=%0d want 00000004/0000 lat=1 pulses=1",
                     res, flg, lat, pulses);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
